dff_bank_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among four requesters. Each requester asks for a burst of 1–4 write cycles. The arbiter grants the register to one requester at a time, steers that requester's data into the flops and pulses a per-requester completion strobe. It sits directly in front of the team's flip-flop storage cells and is the only writer of them.

---
 rtl/dff_bank_rr_arbiter_pkg.sv | 25 ++
 rtl/dff_bank_rr_arbiter_if.sv | 19 +
 rtl/dff_bank_rr_pick4.sv | 22 ++
 rtl/dff_bank_rr_arbiter.sv | 91 +++++++++
 tb/tb_dff_bank_rr_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dff_bank_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin register-bank arbiter.
package dff_bank_rr_arbiter_pkg;

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned LEN_W   = 2;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned LEN_BUS_W = NUM_REQ * LEN_W;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [LEN_W-1:0] len_lane(input logic [LEN_BUS_W-1:0] lens,
                                                input logic [PTR_W-1:0] idx);
    return lens[idx*LEN_W +: LEN_W];
  endfunction

endpackage

// File: rtl/dff_bank_rr_arbiter_if.sv
// Requester-side bundle: request levels, burst lengths, data lanes and arbiter status.
interface dff_bank_rr_arbiter_if
  import dff_bank_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  logic [NUM_REQ-1:0]       req;
  logic [LEN_BUS_W-1:0]     req_len;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [WIDTH-1:0]         q;

  modport master (output req, req_len, wdata, input grant, done, busy, q);
  modport slave  (input req, req_len, wdata, output grant, done, busy, q);

endinterface

// File: rtl/dff_bank_rr_pick4.sv
// Combinational four-way round-robin pick: first request at or after i_ptr, wrapping 3->0.
module rr_pick4
  import dff_bank_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[i_ptr + PTR_W'(k)]) begin
        o_winner[i_ptr + PTR_W'(k)] = 1'b1;
        o_valid                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter granting a shared WIDTH-bit flop bank to one of four burst requesters.
module dff_bank_rr_arbiter
  import dff_bank_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  dff_bank_rr_arbiter_if.slave bus
);

  state_e             r_state, w_state_d;
  logic [NUM_REQ-1:0] r_grant, w_grant_d;
  logic [PTR_W-1:0]   r_ptr, w_ptr_d;
  logic [LEN_W-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]   r_q;

  logic [NUM_REQ-1:0] w_winner;
  logic               w_valid;
  logic [PTR_W-1:0]   w_idx;
  logic               w_live;
  logic               w_we;
  logic [NUM_REQ-1:0] w_done;

  rr_pick4 u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_idx  = onehot_to_idx(r_grant);
  // A granted requester dropping its request aborts the burst.
  assign w_live = |(r_grant & bus.req);

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_we      = 1'b0;
    w_done    = '0;
    case (r_state)
      StIdle: begin
        if (w_valid) begin
          w_grant_d = w_winner;
          w_cnt_d   = len_lane(bus.req_len, onehot_to_idx(w_winner));
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (w_live) begin
          w_we = 1'b1;
          if (r_cnt == '0) w_done = r_grant;
          else             w_cnt_d = r_cnt - 1'b1;
        end
        if (!w_live || r_cnt == '0) begin
          w_grant_d = '0;
          w_ptr_d   = w_idx + 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_q <= '0;
    else if (w_we) r_q <= bus.wdata[w_idx*WIDTH +: WIDTH];
  end

  assign bus.grant = r_grant;
  assign bus.done  = w_done;
  assign bus.busy  = |r_grant;
  assign bus.q     = r_q;

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Scoreboard bench: a per-cycle reference model queues expected outputs, a monitor checks them.
module tb_dff_bank_rr_arbiter;

  localparam int W = 8;

  typedef struct {
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic [W-1:0] q;
  } exp_t;

  logic clk;
  logic reset;

  dff_bank_rr_arbiter_if #(.WIDTH(W)) bus ();

  dff_bank_rr_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  // Reference model state
  bit           m_busy;
  int           m_ptr;
  int           m_win;
  int           m_rem;
  logic [W-1:0] m_q;

  task automatic drive(input logic [3:0] r, input logic [7:0] l, input logic [4*W-1:0] d,
                       input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rn;
    bus.req     = r;
    bus.req_len = l;
    bus.wdata   = d;
    e.grant = '0;
    e.done  = '0;
    e.busy  = 1'b0;
    e.q     = '0;
    if (!rn) begin
      m_busy = 0;
      m_ptr  = 0;
      m_rem  = 0;
      m_q    = '0;
    end else begin
      e.grant = m_busy ? 4'(1 << m_win) : 4'b0;
      e.busy  = m_busy;
      e.q     = m_q;
      if (m_busy) begin
        if (r[m_win]) begin
          m_q = d[m_win*W +: W];
          if (m_rem == 0) begin
            e.done = 4'(1 << m_win);
            m_busy = 0;
            m_ptr  = (m_win + 1) % 4;
          end else begin
            m_rem--;
          end
        end else begin
          m_busy = 0;
          m_ptr  = (m_win + 1) % 4;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && r[(m_ptr + k) % 4]) begin
            m_win  = (m_ptr + k) % 4;
            m_rem  = int'((l >> (2 * m_win)) & 8'd3);
            m_busy = 1;
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.grant !== e.grant || bus.done !== e.done || bus.busy !== e.busy ||
            bus.q !== e.q) begin
          n_err++;
          $display("FAIL cycle %0d: grant=%b/%b done=%b/%b busy=%b/%b q=%h/%h (got/want)",
                   n_vec, bus.grant, e.grant, bus.done, e.done, bus.busy, e.busy, bus.q, e.q);
        end
      end
    end
  end

  function automatic logic [4*W-1:0] lane(input int i, input logic [W-1:0] v);
    logic [4*W-1:0] d;
    d = '0;
    d[i*W +: W] = v;
    return d;
  endfunction

  initial begin
    logic [3:0]     r;
    logic [7:0]     l;
    logic [7:0]     data [4];
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    bus.wdata = '0;
    m_busy = 0;
    m_ptr = 0;
    m_win = 0;
    m_rem = 0;
    m_q = '0;

    // Reset with random activity, then quiet idle
    repeat (2) drive(4'($urandom), 8'($urandom), 32'($urandom), 1'b0);
    repeat (5) drive(4'b0, 8'h00, 32'h0, 1'b1);

    // Single one-cycle burst on requester 0, then check ptr moved to 1
    drive(4'b0001, 8'h00, lane(0, 8'hA5), 1'b1);
    drive(4'b0001, 8'h00, lane(0, 8'hA5), 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);
    drive(4'b1111, 8'h00, 32'h0102_0304, 1'b1);
    drive(4'b1111, 8'h00, 32'h0102_0304, 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);

    // Four-beat burst on requester 2 with changing data
    data = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(4'b0100, 8'h30, lane(2, 8'hEE), 1'b1);
    for (int i = 0; i < 4; i++) drive(4'b0100, 8'h30, lane(2, data[i]), 1'b1);
    repeat (2) drive(4'b0000, 8'h00, 32'h0, 1'b1);

    // Fairness with everybody requesting
    for (int i = 0; i < 16; i++) drive(4'b1111, 8'h00, 32'($urandom), 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);

    // Abort on requester 1 in its second grant cycle; next winner shows ptr=2
    drive(4'b0010, 8'h0C, lane(1, 8'h5A), 1'b1);
    drive(4'b0010, 8'h0C, lane(1, 8'h5A), 1'b1);
    drive(4'b0000, 8'h0C, lane(1, 8'hC3), 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);
    drive(4'b1111, 8'h00, 32'hDEAD_BEEF, 1'b1);
    drive(4'b1111, 8'h00, 32'hDEAD_BEEF, 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);

    // Reset in the middle of a four-beat burst
    drive(4'b0001, 8'h03, lane(0, 8'h77), 1'b1);
    drive(4'b0001, 8'h03, lane(0, 8'h78), 1'b1);
    drive(4'b0001, 8'h03, lane(0, 8'h79), 1'b0);
    drive(4'b1111, 8'h00, 32'h1234_5678, 1'b1);
    drive(4'b1111, 8'h00, 32'h1234_5678, 1'b1);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);

    // Random traffic with occasional drops and resets
    r = 4'b0;
    l = 8'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) l = 8'($urandom);
      drive(r, l, 32'($urandom), ($urandom_range(0, 400) != 0));
    end

    repeat (3) drive(4'b0000, 8'h00, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
